// File: rtl/exe_flag_stage_if.sv
// ALU-to-writeback handshake bundle for the execute flag stage.
// master drives the ALU-side inputs and the writeback ready; slave is the stage itself.
interface exe_flag_stage_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] alu_y;
    logic         alu_cb;
    logic         alu_op;
    logic         a_msb;
    logic         b_msb;
    logic         set_flags;
    logic [3:0]   cond;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_y;
    logic         out_wr_en;
    logic [3:0]   flags;

    modport master (
        output in_valid, alu_y, alu_cb, alu_op, a_msb, b_msb, set_flags, cond, flush, out_ready,
        input  in_ready, out_valid, out_y, out_wr_en, flags
    );

    modport slave (
        input  in_valid, alu_y, alu_cb, alu_op, a_msb, b_msb, set_flags, cond, flush, out_ready,
        output in_ready, out_valid, out_y, out_wr_en, flags
    );
endinterface

// File: rtl/exe_flag_stage.sv
// Execute-stage output register: captures the ALU result, evaluates the ARM condition against NZCV,
// updates NZCV on S. Optional performance counters are enabled with `define EXE_PERF_CNT_EN.
module exe_flag_stage #(
    parameter int N = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    exe_flag_stage_if.slave bus
`ifdef EXE_PERF_CNT_EN
    ,
    output logic [31:0]     cnt_exec,
    output logic [31:0]     cnt_skip
`endif
);

    logic         valid_q, valid_d;
    logic [N-1:0] y_q, y_d;
    logic         wr_en_q, wr_en_d;
    logic [3:0]   flags_q, flags_d;

    logic       accept;
    logic       cond_pass;
    logic [3:0] nzcv_new;
    logic       fn, fz, fc, fv;
    logic       ym;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

    assign {fn, fz, fc, fv} = flags_q;
    assign ym               = bus.alu_y[N-1];

    // Condition is judged against the flags as they stand before this instruction writes them.
    always_comb begin
        case (bus.cond)
            4'b0000: cond_pass = fz;
            4'b0001: cond_pass = !fz;
            4'b0010: cond_pass = fc;
            4'b0011: cond_pass = !fc;
            4'b0100: cond_pass = fn;
            4'b0101: cond_pass = !fn;
            4'b0110: cond_pass = fv;
            4'b0111: cond_pass = !fv;
            4'b1000: cond_pass = fc && !fz;
            4'b1001: cond_pass = !fc || fz;
            4'b1010: cond_pass = (fn == fv);
            4'b1011: cond_pass = (fn != fv);
            4'b1100: cond_pass = !fz && (fn == fv);
            4'b1101: cond_pass = fz || (fn != fv);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // ARM carry on subtract is the inverse of the ALU borrow.
    assign nzcv_new[3] = ym;
    assign nzcv_new[2] = (bus.alu_y == '0);
    assign nzcv_new[1] = bus.alu_op ? ~bus.alu_cb : bus.alu_cb;
    assign nzcv_new[0] = bus.alu_op ? ((bus.a_msb != bus.b_msb) && (ym != bus.a_msb))
                                    : ((bus.a_msb == bus.b_msb) && (ym != bus.a_msb));

    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        wr_en_d = wr_en_q;
        flags_d = flags_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            y_d     = bus.alu_y;
            wr_en_d = cond_pass;
            if (bus.set_flags && cond_pass) begin
                flags_d = nzcv_new;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            wr_en_q <= 1'b0;
            flags_q <= 4'b0000;
        end else begin
            valid_q <= valid_d;
            y_q     <= y_d;
            wr_en_q <= wr_en_d;
            flags_q <= flags_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_y     = y_q;
    assign bus.out_wr_en = wr_en_q;
    assign bus.flags     = flags_q;

`ifdef EXE_PERF_CNT_EN
    logic [31:0] exec_q, exec_d;
    logic [31:0] skip_q, skip_d;

    // Only accepted entries are counted; flushed ones never reach accept.
    always_comb begin
        exec_d = exec_q;
        skip_d = skip_q;
        if (accept) begin
            if (cond_pass) exec_d = exec_q + 32'd1;
            else           skip_d = skip_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exec_q <= '0;
            skip_q <= '0;
        end else begin
            exec_q <= exec_d;
            skip_q <= skip_d;
        end
    end

    assign cnt_exec = exec_q;
    assign cnt_skip = skip_q;
`endif

endmodule
